// File: rtl/ultrasonic_pkg.sv
// rtl/ultrasonic_pkg.sv - shared types and 40 MHz timing constants for the ultrasonic front end
package ultrasonic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    LISTEN,
    QUALIFY
  } echo_state_t;

  localparam int CNT_W_DEFAULT = 20;

  // Cycle constants for CLK_40, shared with the transmitter timing.
  localparam int CLK_HZ                 = 40_000_000;
  localparam int CYCLES_PER_US          = 40;
  localparam int CYCLES_PER_MS          = 40_000;
  localparam int BURST_PERIOD_CYCLES    = 14 * CYCLES_PER_MS;
  localparam int BLANK_CYCLES_DEFAULT   = CYCLES_PER_MS;
  localparam int TIMEOUT_CYCLES_DEFAULT = 520_000;
  localparam int ECHO_MIN_DEFAULT       = 8;

endpackage

// File: rtl/ultrasonic_echo_timer_if.sv
// rtl/ultrasonic_echo_timer_if.sv - time-of-flight result port (valid/ready) toward the logger
interface ultrasonic_echo_timer_if #(
  parameter int CNT_W = ultrasonic_pkg::CNT_W_DEFAULT
);

  logic [CNT_W-1:0] TOF;
  logic             TOF_TIMEOUT;
  logic             TOF_VALID;
  logic             TOF_READY;

  modport master (
    output TOF,
    output TOF_TIMEOUT,
    output TOF_VALID,
    input  TOF_READY
  );

  modport slave (
    input  TOF,
    input  TOF_TIMEOUT,
    input  TOF_VALID,
    output TOF_READY
  );

endinterface

// File: rtl/echo_input_sync.sv
// rtl/echo_input_sync.sv - two-flop synchroniser for the asynchronous comparator output
module echo_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ultrasonic_echo_timer.sv
// rtl/ultrasonic_echo_timer.sv - blanks transmitter ringing, qualifies the echo and reports time-of-flight
module ultrasonic_echo_timer
  import ultrasonic_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEFAULT,
  parameter int BLANK_CYCLES   = BLANK_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int ECHO_MIN       = ECHO_MIN_DEFAULT
) (
  input  logic CLK_40,
  input  logic RST,
  input  logic ON,
  input  logic BURST_START,
  input  logic ECHO_IN,
  ultrasonic_echo_timer_if.master res,
  output logic OVERRUN,
  output logic BUSY
);

  localparam int RUN_W = $clog2(ECHO_MIN + 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_LAST     = RUN_W'(ECHO_MIN - 1);

  echo_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cand;
  logic [RUN_W-1:0] run;
  logic             echo_s;

  logic             emit;
  logic [CNT_W-1:0] emit_tof;
  logic             emit_timeout;

  echo_input_sync u_sync (
    .clk   (CLK_40),
    .rst_n (RST),
    .d     (ECHO_IN),
    .q     (echo_s)
  );

  // A restart strobe or disable in the same cycle swallows any result.
  always_comb begin
    emit         = 1'b0;
    emit_tof     = cand;
    emit_timeout = 1'b0;
    if (ON && !BURST_START) begin
      case (state)
        LISTEN, QUALIFY: begin
          if (cnt == TIMEOUT_LAST) begin
            emit         = 1'b1;
            emit_tof     = CNT_MAX;
            emit_timeout = 1'b1;
          end else if (state == QUALIFY && echo_s && run == RUN_LAST) begin
            emit = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_40 or negedge RST) begin
    if (!RST) begin
      state           <= IDLE;
      cnt             <= '0;
      cand            <= '0;
      run             <= '0;
      res.TOF         <= '0;
      res.TOF_TIMEOUT <= 1'b0;
      res.TOF_VALID   <= 1'b0;
      OVERRUN         <= 1'b0;
    end else begin
      if (!ON) begin
        state <= IDLE;
      end else if (BURST_START) begin
        cnt   <= '0;
        state <= BLANK;
      end else begin
        if (state != IDLE && cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
        case (state)
          BLANK: begin
            if (cnt == BLANK_LAST) state <= LISTEN;
          end
          LISTEN: begin
            if (emit) begin
              state <= IDLE;
            end else if (echo_s) begin
              cand  <= cnt;
              run   <= RUN_W'(1);
              state <= QUALIFY;
            end
          end
          QUALIFY: begin
            if (emit) begin
              state <= IDLE;
            end else if (echo_s) begin
              run <= run + 1'b1;
            end else begin
              state <= LISTEN;
            end
          end
          default: ;
        endcase
      end

      // Result register: a held result is never overwritten until consumed.
      if (emit) begin
        if (!res.TOF_VALID || res.TOF_READY) begin
          res.TOF         <= emit_tof;
          res.TOF_TIMEOUT <= emit_timeout;
          res.TOF_VALID   <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (res.TOF_READY) begin
        res.TOF_VALID <= 1'b0;
      end
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_ultrasonic_echo_timer.sv
// tb/tb_ultrasonic_echo_timer.sv - scoreboard bench for ultrasonic_echo_timer with scaled timing
module tb_ultrasonic_echo_timer;

  localparam int CNT_W          = 20;
  localparam int BLANK_CYCLES   = 400;
  localparam int TIMEOUT_CYCLES = 5200;
  localparam int ECHO_MIN       = 8;

  typedef struct {
    logic             to;
    logic [CNT_W-1:0] tof;
  } exp_t;

  logic CLK_40 = 1'b0;
  logic RST;
  logic ON;
  logic BURST_START;
  logic ECHO_IN;
  logic OVERRUN;
  logic BUSY;

  ultrasonic_echo_timer_if #(.CNT_W(CNT_W)) res_if ();

  ultrasonic_echo_timer #(
    .CNT_W          (CNT_W),
    .BLANK_CYCLES   (BLANK_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .ECHO_MIN       (ECHO_MIN)
  ) dut (
    .CLK_40      (CLK_40),
    .RST         (RST),
    .ON          (ON),
    .BURST_START (BURST_START),
    .ECHO_IN     (ECHO_IN),
    .res         (res_if),
    .OVERRUN     (OVERRUN),
    .BUSY        (BUSY)
  );

  always #5 CLK_40 = ~CLK_40;

  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  exp_t sb[$];

  task automatic expect_result(input logic to, input int tof);
    exp_t x;
    x.to  = to;
    x.tof = CNT_W'(tof);
    sb.push_back(x);
  endtask

  // Inputs are set before calling tick; the handshake the coming edge will see is scored here.
  task automatic tick();
    exp_t x;
    if (res_if.TOF_VALID === 1'b1 && res_if.TOF_READY === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result tof=%0d timeout=%0b required no result", res_if.TOF, res_if.TOF_TIMEOUT);
      end else begin
        x = sb.pop_front();
        if (res_if.TOF !== x.tof || res_if.TOF_TIMEOUT !== x.to) begin
          errors++;
          $display("FAIL result tof=%0d timeout=%0b required tof=%0d timeout=%0b",
                   res_if.TOF, res_if.TOF_TIMEOUT, x.tof, x.to);
        end
      end
    end
    @(posedge CLK_40);
    k++;
    #2;
  endtask

  task automatic tick_to(input int target);
    while (k < target) tick();
  endtask

  task automatic do_burst();
    BURST_START = 1'b1;
    tick();
    k = 0;
    BURST_START = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0 within %0d cycles", sb.size(), budget);
    end else begin
      checks++;
      if (res_if.TOF_VALID !== 1'b0) begin
        errors++;
        $display("FAIL valid_fall valid=%0b required 0", res_if.TOF_VALID);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({res_if.TOF, res_if.TOF_TIMEOUT, res_if.TOF_VALID, OVERRUN, BUSY} !== '0) begin
      errors++;
      $display("FAIL reset_outputs tof=%0d to=%0b v=%0b ovr=%0b busy=%0b required all 0",
               res_if.TOF, res_if.TOF_TIMEOUT, res_if.TOF_VALID, OVERRUN, BUSY);
    end
    tick();
    tick();
    RST = 1'b1;
    tick();
    do_burst();
    tick_to(600);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL busy_listen busy=%0b required 1", BUSY);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({res_if.TOF, res_if.TOF_TIMEOUT, res_if.TOF_VALID, OVERRUN, BUSY} !== '0) begin
      errors++;
      $display("FAIL async_reset tof=%0d to=%0b v=%0b ovr=%0b busy=%0b required all 0",
               res_if.TOF, res_if.TOF_TIMEOUT, res_if.TOF_VALID, OVERRUN, BUSY);
    end
    tick();
    RST = 1'b1;
    repeat (5) tick();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_reset busy=%0b required 0", BUSY);
    end
  endtask

  task automatic test_nominal();
    int edges[3] = '{BLANK_CYCLES - 1, 600, 1234};
    res_if.TOF_READY = 1'b1;
    foreach (edges[i]) begin
      do_burst();
      tick_to(edges[i] - 1);
      ECHO_IN = 1'b1;
      expect_result(1'b0, edges[i] + 1);
      tick_to(edges[i] - 1 + 20);
      ECHO_IN = 1'b0;
      wait_drain(50);
      checks++;
      if (BUSY !== 1'b0) begin
        errors++;
        $display("FAIL nominal_idle e=%0d busy=%0b required 0", edges[i], BUSY);
      end
    end
  endtask

  task automatic test_blank_glitch();
    res_if.TOF_READY = 1'b1;
    do_burst();
    tick_to(9);
    ECHO_IN = 1'b1;
    tick_to(50);
    ECHO_IN = 1'b0;
    tick_to(699);
    ECHO_IN = 1'b1;
    tick_to(704);
    ECHO_IN = 1'b0;
    tick_to(750);
    checks++;
    if (res_if.TOF_VALID !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL glitch_rejected valid=%0b busy=%0b required valid 0 busy 1", res_if.TOF_VALID, BUSY);
    end
    expect_result(1'b0, 801);
    tick_to(799);
    ECHO_IN = 1'b1;
    tick_to(830);
    ECHO_IN = 1'b0;
    wait_drain(50);
  endtask

  task automatic test_timeout();
    res_if.TOF_READY = 1'b0;
    do_burst();
    tick_to(TIMEOUT_CYCLES - 1);
    checks++;
    if (res_if.TOF_VALID !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early valid=%0b required 0", res_if.TOF_VALID);
    end
    tick();
    checks++;
    if (res_if.TOF_VALID !== 1'b1 || res_if.TOF !== 20'hFFFFF || res_if.TOF_TIMEOUT !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result v=%0b tof=%0h to=%0b busy=%0b required v=1 tof=fffff to=1 busy=0",
               res_if.TOF_VALID, res_if.TOF, res_if.TOF_TIMEOUT, BUSY);
    end
    expect_result(1'b1, 20'hFFFFF);
    res_if.TOF_READY = 1'b1;
    wait_drain(5);
    // Echo whose qualification would finish after the timeout point.
    do_burst();
    tick_to(TIMEOUT_CYCLES - 7);
    ECHO_IN = 1'b1;
    expect_result(1'b1, 20'hFFFFF);
    tick_to(TIMEOUT_CYCLES + 10);
    ECHO_IN = 1'b0;
    wait_drain(5);
  endtask

  task automatic test_backpressure();
    res_if.TOF_READY = 1'b0;
    do_burst();
    tick_to(499);
    ECHO_IN = 1'b1;
    expect_result(1'b0, 501);
    tick_to(520);
    ECHO_IN = 1'b0;
    tick_to(600);
    checks++;
    if (res_if.TOF_VALID !== 1'b1 || res_if.TOF !== 20'd501 || OVERRUN !== 1'b0) begin
      errors++;
      $display("FAIL bp_first v=%0b tof=%0d ovr=%0b required v=1 tof=501 ovr=0", res_if.TOF_VALID, res_if.TOF, OVERRUN);
    end
    do_burst();
    tick_to(449);
    ECHO_IN = 1'b1;
    tick_to(470);
    ECHO_IN = 1'b0;
    tick_to(500);
    checks++;
    if (res_if.TOF_VALID !== 1'b1 || res_if.TOF !== 20'd501 || OVERRUN !== 1'b1) begin
      errors++;
      $display("FAIL bp_held v=%0b tof=%0d ovr=%0b required v=1 tof=501 ovr=1", res_if.TOF_VALID, res_if.TOF, OVERRUN);
    end
    res_if.TOF_READY = 1'b1;
    wait_drain(5);
    checks++;
    if (OVERRUN !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky ovr=%0b required 1", OVERRUN);
    end
  endtask

  task automatic test_restart();
    res_if.TOF_READY = 1'b1;
    do_burst();
    tick_to(450);
    do_burst();
    checks++;
    if (BUSY !== 1'b1 || res_if.TOF_VALID !== 1'b0) begin
      errors++;
      $display("FAIL restart_state busy=%0b v=%0b required busy=1 v=0", BUSY, res_if.TOF_VALID);
    end
    tick_to(419);
    ECHO_IN = 1'b1;
    expect_result(1'b0, 421);
    tick_to(440);
    ECHO_IN = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_enable();
    res_if.TOF_READY = 1'b1;
    do_burst();
    tick_to(449);
    ECHO_IN = 1'b1;
    tick_to(453);
    ON = 1'b0;
    tick();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL on_low_idle busy=%0b required 0", BUSY);
    end
    tick_to(480);
    checks++;
    if (res_if.TOF_VALID !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL on_low_no_result v=%0b pending=%0d required v=0 pending=0", res_if.TOF_VALID, sb.size());
    end
    ECHO_IN = 1'b0;
    BURST_START = 1'b1;
    tick();
    BURST_START = 1'b0;
    tick();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL burst_while_off busy=%0b required 0", BUSY);
    end
    ON = 1'b1;
  endtask

  initial begin
    RST              = 1'b0;
    ON               = 1'b1;
    BURST_START      = 1'b0;
    ECHO_IN          = 1'b0;
    res_if.TOF_READY = 1'b0;
    test_reset();
    test_nominal();
    test_blank_glitch();
    test_timeout();
    test_backpressure();
    test_restart();
    test_enable();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_scoreboard pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
